// File: rtl/chain_score_max_if.sv
// rtl/chain_score_max_if.sv - beat input and anchor result handshake bundle for chain_score_max
interface chain_score_max_if #(
    parameter int IDX_W = 16,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_score;
    logic [31:0]      in_pred_f;
    logic [IDX_W-1:0] in_pred_idx;
    logic [31:0]      in_anchor_w;
    logic             in_nopred;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_f;
    logic [IDX_W-1:0] out_p;
    logic [CNT_W-1:0] out_cnt;
    logic [IDX_W-1:0] out_anchor_idx;

    modport master (
        output in_valid, in_score, in_pred_f, in_pred_idx, in_anchor_w, in_nopred, in_last,
        input  in_ready,
        input  out_valid, out_f, out_p, out_cnt, out_anchor_idx,
        output out_ready
    );

    modport slave (
        input  in_valid, in_score, in_pred_f, in_pred_idx, in_anchor_w, in_nopred, in_last,
        output in_ready,
        output out_valid, out_f, out_p, out_cnt, out_anchor_idx,
        input  out_ready
    );
endinterface

// File: rtl/chain_score_max.sv
// rtl/chain_score_max.sv - per-anchor max over predecessor chain scores with saturating add
module chain_score_max #(
    parameter int IDX_W = 16,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    chain_score_max_if.slave   bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCUM  = 2'd1;
    localparam logic [1:0] OUTPUT = 2'd2;

    logic [1:0]       state;
    logic [31:0]      best_f;
    logic [IDX_W-1:0] best_p;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] anchor_idx;

    logic             accept;
    logic signed [32:0] sum;
    logic [31:0]      cand;
    logic [31:0]      base_f;
    logic [IDX_W-1:0] base_p;
    logic [CNT_W-1:0] base_cnt;
    logic [31:0]      nxt_f;
    logic [IDX_W-1:0] nxt_p;
    logic [CNT_W-1:0] nxt_cnt;

    assign bus.in_ready       = (state != OUTPUT);
    assign bus.out_valid      = (state == OUTPUT);
    assign bus.out_f          = best_f;
    assign bus.out_p          = best_p;
    assign bus.out_cnt        = cnt;
    assign bus.out_anchor_idx = anchor_idx;

    assign accept = bus.in_valid && (state != OUTPUT);

    // 33-bit sum; a disagreement between the top two bits means overflow.
    assign sum = $signed({bus.in_pred_f[31], bus.in_pred_f}) + $signed({bus.in_score[31], bus.in_score});

    always_comb begin
        cand = sum[31:0];
        if (sum[32] != sum[31]) begin
            cand = sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
    end

    // The first beat of an anchor seeds the accumulator before it is evaluated.
    always_comb begin
        base_f   = best_f;
        base_p   = best_p;
        base_cnt = cnt;
        if (state == IDLE) begin
            base_f   = bus.in_anchor_w;
            base_p   = '1;
            base_cnt = '0;
        end
        nxt_f   = base_f;
        nxt_p   = base_p;
        nxt_cnt = base_cnt;
        if (!bus.in_nopred) begin
            nxt_cnt = (&base_cnt) ? base_cnt : base_cnt + CNT_W'(1);
            if ($signed(cand) > $signed(base_f)) begin
                nxt_f = cand;
                nxt_p = bus.in_pred_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            best_f     <= '0;
            best_p     <= '1;
            cnt        <= '0;
            anchor_idx <= '0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        best_f <= nxt_f;
                        best_p <= nxt_p;
                        cnt    <= nxt_cnt;
                        state  <= bus.in_last ? OUTPUT : ACCUM;
                    end
                end
                OUTPUT: begin
                    if (bus.out_ready) begin
                        state      <= IDLE;
                        anchor_idx <= anchor_idx + IDX_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_chain_score_max.sv
// tb/tb_chain_score_max.sv - table, corner-case and randomized checks of chain_score_max
module tb_chain_score_max;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    chain_score_max_if #(.IDX_W(16), .CNT_W(8)) ifc ();
    chain_score_max #(.IDX_W(16), .CNT_W(8)) dut (.clk(clk), .reset(reset), .bus(ifc));

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] exp_idx = '0;

    int q_f[$];
    int q_s[$];
    int q_j[$];
    bit q_n[$];

    typedef struct {
        logic [31:0]      aw;
        int               n;
        logic [2:0][31:0] f;
        logic [2:0][31:0] s;
        logic [2:0][15:0] j;
        logic [2:0]       nop;
        logic [31:0]      ef;
        logic [15:0]      ep;
        logic [7:0]       ec;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: best of anchor weight and clamped pred_f + score, earliest wins ties.
    task automatic model(input int aw, output logic [31:0] f, output logic [15:0] p, output logic [7:0] c);
        longint best = longint'(aw);
        int cc = 0;
        p = 16'hFFFF;
        foreach (q_f[i]) begin
            if (!q_n[i]) begin
                longint s = longint'(q_f[i]) + longint'(q_s[i]);
                if (s > 64'sd2147483647) s = 64'sd2147483647;
                if (s < -64'sd2147483648) s = -64'sd2147483648;
                if (s > best) begin
                    best = s;
                    p = q_j[i][15:0];
                end
                if (cc < 255) cc++;
            end
        end
        f = best[31:0];
        c = cc[7:0];
    endtask

    function automatic int rval();
        case ($urandom_range(0, 3))
            0: rval = 32'h7FFF_FFFF - $urandom_range(0, 50);
            1: rval = 32'h8000_0000 + $urandom_range(0, 50);
            default: rval = int'($urandom_range(0, 2000)) - 1000;
        endcase
    endfunction

    task automatic garbage();
        ifc.in_score    = $urandom;
        ifc.in_pred_f   = $urandom;
        ifc.in_pred_idx = 16'($urandom);
        ifc.in_anchor_w = $urandom;
        ifc.in_nopred   = 1'($urandom);
        ifc.in_last     = 1'($urandom);
    endtask

    task automatic drive_beats(input logic [31:0] aw, input bit gaps);
        int n;
        for (int k = 0; k < q_f.size(); k++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                ifc.in_valid = 1'b0;
                garbage();
                @(negedge clk);
            end
            ifc.in_valid    = 1'b1;
            ifc.in_pred_f   = q_f[k];
            ifc.in_score    = q_s[k];
            ifc.in_pred_idx = q_j[k][15:0];
            ifc.in_nopred   = q_n[k];
            ifc.in_anchor_w = (k == 0) ? aw : $urandom;
            ifc.in_last     = (k == q_f.size() - 1);
            n = 0;
            while (!ifc.in_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (n == 20) chk("in_ready_timeout", 64'd0, 64'd1);
            @(negedge clk);
        end
        ifc.in_valid = 1'b0;
        garbage();
        chk("latency_out_valid", 64'(ifc.out_valid), 64'd1);
    endtask

    task automatic check_out(input logic [31:0] ef, input logic [15:0] ep, input logic [7:0] ec);
        chk("out_f", 64'(ifc.out_f), 64'(ef));
        chk("out_p", 64'(ifc.out_p), 64'(ep));
        chk("out_cnt", 64'(ifc.out_cnt), 64'(ec));
        chk("out_anchor_idx", 64'(ifc.out_anchor_idx), 64'(exp_idx));
    endtask

    task automatic finish_out(input int rdly);
        logic [63:0] held;
        held = {ifc.out_f, ifc.out_p, ifc.out_cnt};
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            chk("hold_stable", {ifc.out_f, ifc.out_p, ifc.out_cnt}, held);
            chk("hold_valid", 64'(ifc.out_valid), 64'd1);
        end
        ifc.out_ready = 1'b1;
        @(negedge clk);
        ifc.out_ready = 1'b0;
        exp_idx = exp_idx + 16'd1;
        chk("handshake_valid_drop", 64'(ifc.out_valid), 64'd0);
        chk("idx_advance", 64'(ifc.out_anchor_idx), 64'(exp_idx));
    endtask

    task automatic clear_q();
        q_f.delete(); q_s.delete(); q_j.delete(); q_n.delete();
    endtask

    task automatic push(input int f, input int s, input int j, input bit nop);
        q_f.push_back(f); q_s.push_back(s); q_j.push_back(j); q_n.push_back(nop);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] mf;
        logic [15:0] mp;
        logic [7:0]  mc;
        logic [63:0] held;
        int aw;

        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b0;
        garbage();
        tbl[0] = '{aw: 32'd10, n: 3, f: {32'd12, 32'd30, 32'd20}, s: {32'd3, 32'hFFFF_FFD8, 32'hFFFF_FFFB},
                   j: {16'd7, 16'd4, 16'd3}, nop: 3'b000, ef: 32'd15, ep: 16'd3, ec: 8'd3};
        tbl[1] = '{aw: 32'hFFFF_FFFE, n: 1, f: '0, s: '0, j: '0, nop: 3'b001,
                   ef: 32'hFFFF_FFFE, ep: 16'hFFFF, ec: 8'd0};
        tbl[2] = '{aw: 32'd0, n: 2, f: {32'd0, 32'h7FFF_FFFF, 32'h7FFF_FFF0}, s: {32'd0, 32'd0, 32'h100},
                   j: {16'd0, 16'd2, 16'd1}, nop: 3'b000, ef: 32'h7FFF_FFFF, ep: 16'd1, ec: 8'd2};
        tbl[3] = '{aw: 32'h8000_0000, n: 1, f: {32'd0, 32'd0, 32'h8000_0000}, s: {32'd0, 32'd0, 32'hFFFF_FFFF},
                   j: {16'd0, 16'd0, 16'd5}, nop: 3'b000, ef: 32'h8000_0000, ep: 16'hFFFF, ec: 8'd1};
        tbl[4] = '{aw: 32'd5, n: 2, f: {32'd0, 32'd3, 32'd0}, s: {32'd0, 32'd4, 32'd0},
                   j: {16'd0, 16'd2, 16'd0}, nop: 3'b001, ef: 32'd7, ep: 16'd2, ec: 8'd1};
        tbl[5] = '{aw: 32'd7, n: 1, f: {32'd0, 32'd0, 32'd3}, s: {32'd0, 32'd0, 32'd4},
                   j: {16'd0, 16'd0, 16'd9}, nop: 3'b000, ef: 32'd7, ep: 16'hFFFF, ec: 8'd1};
        tbl[6] = '{aw: 32'hFFFF_FF9C, n: 1, f: {32'd0, 32'd0, 32'hFFFF_FFCE}, s: {32'd0, 32'd0, 32'hFFFF_FFF6},
                   j: {16'd0, 16'd0, 16'd4}, nop: 3'b000, ef: 32'hFFFF_FFC4, ep: 16'd4, ec: 8'd1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_in_ready", 64'(ifc.in_ready), 64'd1);
        chk("rst_out_valid", 64'(ifc.out_valid), 64'd0);
        chk("rst_out_f", 64'(ifc.out_f), 64'd0);
        chk("rst_out_p", 64'(ifc.out_p), 64'hFFFF);
        chk("rst_out_cnt", 64'(ifc.out_cnt), 64'd0);
        chk("rst_anchor_idx", 64'(ifc.out_anchor_idx), 64'd0);

        // Backpressure with a beat stalled against a held result.
        clear_q();
        push(20, -5, 3, 0); push(30, -40, 4, 0); push(12, 3, 7, 0);
        drive_beats(32'd10, 1'b0);
        check_out(32'd15, 16'd3, 8'd3);
        held = {ifc.out_f, ifc.out_p, ifc.out_cnt};
        ifc.in_valid = 1'b1; ifc.in_anchor_w = 32'd5; ifc.in_pred_f = 32'd1; ifc.in_score = 32'd1;
        ifc.in_pred_idx = 16'd9; ifc.in_nopred = 1'b0; ifc.in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(ifc.in_ready), 64'd0);
            chk("bp_stable", {ifc.out_f, ifc.out_p, ifc.out_cnt}, held);
            chk("bp_out_valid", 64'(ifc.out_valid), 64'd1);
        end
        ifc.out_ready = 1'b1;
        @(negedge clk);
        ifc.out_ready = 1'b0;
        exp_idx = 16'd1;
        chk("bp_handshake_valid", 64'(ifc.out_valid), 64'd0);
        chk("bp_idx_0_to_1", 64'(ifc.out_anchor_idx), 64'd1);
        chk("bp_ready_after", 64'(ifc.in_ready), 64'd1);
        @(negedge clk);
        ifc.in_valid = 1'b0;
        garbage();
        chk("bp_stalled_beat_latency", 64'(ifc.out_valid), 64'd1);
        check_out(32'd5, 16'hFFFF, 8'd1);
        finish_out(0);
        chk("bp_single_handshake", 64'(ifc.out_anchor_idx), 64'd2);

        for (int v = 0; v < 7; v++) begin
            clear_q();
            for (int k = 0; k < tbl[v].n; k++)
                push(int'(tbl[v].f[k]), int'(tbl[v].s[k]), int'(tbl[v].j[k]), tbl[v].nop[k]);
            drive_beats(tbl[v].aw, v[0]);
            check_out(tbl[v].ef, tbl[v].ep, tbl[v].ec);
            finish_out(int'($urandom_range(0, 3)));
        end

        // Reset after 2 of 4 beats discards the partial anchor.
        ifc.in_valid = 1'b1; ifc.in_anchor_w = 32'd100; ifc.in_pred_f = 32'd500; ifc.in_score = 32'd0;
        ifc.in_pred_idx = 16'd1; ifc.in_nopred = 1'b0; ifc.in_last = 1'b0;
        @(negedge clk);
        ifc.in_pred_idx = 16'd2;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ifc.in_valid = 1'b0;
        exp_idx = '0;
        chk("midrst_in_ready", 64'(ifc.in_ready), 64'd1);
        chk("midrst_out_valid", 64'(ifc.out_valid), 64'd0);
        chk("midrst_out_cnt", 64'(ifc.out_cnt), 64'd0);
        clear_q();
        push(1, 1, 9, 0);
        drive_beats(32'd5, 1'b0);
        check_out(32'd5, 16'hFFFF, 8'd1);
        finish_out(1);

        // Count saturation over 300 losing predecessors.
        clear_q();
        for (int k = 0; k < 300; k++) push(int'($urandom_range(0, 900)), int'($urandom_range(0, 50)), k, 0);
        drive_beats(32'd1000, 1'b0);
        check_out(32'd1000, 16'hFFFF, 8'd255);
        finish_out(0);

        for (int a = 0; a < 60; a++) begin
            int nb;
            clear_q();
            nb = int'($urandom_range(1, 6));
            for (int k = 0; k < nb; k++)
                push(rval(), rval(), int'($urandom_range(0, 65535)), ($urandom_range(0, 4) == 0));
            aw = rval();
            model(aw, mf, mp, mc);
            drive_beats(aw, 1'b1);
            check_out(mf, mp, mc);
            finish_out(int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
